// File: rtl/line_buffer_ctrl_pkg.sv
// Shared conv package: controller state encoding and padded-geometry helpers.
package line_buffer_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } lb_state_t;

    function automatic int padded_dim(input int n, input int pad);
        return n + 2 * pad;
    endfunction

    function automatic int win_count(input int ph, input int pw, input int kh, input int kw);
        return (ph - kh + 1) * (pw - kw + 1);
    endfunction

    // Counter width with a one-bit floor so degenerate 1-wide maps still elaborate.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/line_buffer_ctrl_pad_scan_counter.sv
// Raster scan over the padded map: holds (r,c), wraps, and decodes pad / last / window position.
module pad_scan_counter
    import line_buffer_ctrl_pkg::*;
#(
    parameter int Kh    = 3,
    parameter int Kw    = 3,
    parameter int h     = 5,
    parameter int w     = 5,
    parameter int pad_h = 1,
    parameter int pad_w = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic step,
    output logic pad,
    output logic last,
    output logic win_pos
);

    localparam int PH = padded_dim(h, pad_h);
    localparam int PW = padded_dim(w, pad_w);
    localparam int RW = cnt_width(PH);
    localparam int CW = cnt_width(PW);

    logic [RW-1:0] r;
    logic [CW-1:0] c;
    int            ri;
    int            ci;

    assign ri = int'(r);
    assign ci = int'(c);

    assign pad     = (ri < pad_h) || (ri >= pad_h + h) || (ci < pad_w) || (ci >= pad_w + w);
    assign last    = (ri == PH - 1) && (ci == PW - 1);
    assign win_pos = (ri >= Kh - 1) && (ci >= Kw - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r <= '0;
            c <= '0;
        end else if (clear) begin
            r <= '0;
            c <= '0;
        end else if (step) begin
            if (ci == PW - 1) begin
                c <= '0;
                r <= (ri == PH - 1) ? '0 : r + 1'b1;
            end else begin
                c <= c + 1'b1;
            end
        end
    end

endmodule

// File: rtl/line_buffer_ctrl.sv
// Line-buffer front-end controller: injects zero padding, paces upstream pixels and flags window positions.
module line_buffer_ctrl
    import line_buffer_ctrl_pkg::*;
#(
    parameter int Kh        = 3,
    parameter int Kw        = 3,
    parameter int h         = 5,
    parameter int w         = 5,
    parameter int pad_h     = 1,
    parameter int pad_w     = 1,
    parameter int BIT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] in_data,
    output logic                 lb_valid,
    output logic                 lb_zero,
    output logic [BIT_WIDTH-1:0] lb_data,
    output logic                 win_valid,
    input  logic                 win_ready,
    output logic                 busy,
    output logic                 done
);

    lb_state_t state;
    logic      pad;
    logic      last;
    logic      win_pos;
    logic      adv;
    logic      run;
    logic      shift;

    // A pending window that is not accepted freezes the whole scan.
    assign adv   = !win_valid || win_ready;
    assign run   = (state == RUN);
    assign shift = run && adv && (pad || in_valid);

    assign lb_valid = shift;
    assign lb_zero  = pad;
    assign lb_data  = in_data;
    assign in_ready = run && !pad && adv;
    assign busy     = (state != IDLE);

    pad_scan_counter #(
        .Kh    (Kh),
        .Kw    (Kw),
        .h     (h),
        .w     (w),
        .pad_h (pad_h),
        .pad_w (pad_w)
    ) u_scan (
        .clk     (clk),
        .rst     (rst),
        .clear   ((state == IDLE) && start),
        .step    (shift),
        .pad     (pad),
        .last    (last),
        .win_pos (win_pos)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            win_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (shift && win_pos) begin
                win_valid <= 1'b1;
            end else if (win_ready) begin
                win_valid <= 1'b0;
            end
            case (state)
                IDLE:    if (start) state <= RUN;
                RUN:     if (shift && last) state <= DRAIN;
                DRAIN: begin
                    // The final window is always pending here; its acceptance ends the frame.
                    if (win_valid && win_ready) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench for line_buffer_ctrl: default 5x5/pad 1 frames plus an unpadded 3x3 instance.
module tb_line_buffer_ctrl;

    localparam int PW = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start, in_valid, in_ready, lb_valid, lb_zero, win_valid, win_ready, busy, done;
    logic [15:0] in_data, lb_data;
    logic        start_s, in_valid_s, in_ready_s, lb_valid_s, lb_zero_s;
    logic        win_valid_s, win_ready_s, busy_s, done_s;
    logic [15:0] in_data_s, lb_data_s;

    always #5 clk = ~clk;

    line_buffer_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .lb_valid(lb_valid), .lb_zero(lb_zero), .lb_data(lb_data),
        .win_valid(win_valid), .win_ready(win_ready), .busy(busy), .done(done)
    );

    line_buffer_ctrl #(.Kh(3), .Kw(3), .h(3), .w(3), .pad_h(0), .pad_w(0), .BIT_WIDTH(16)) dut0 (
        .clk(clk), .rst(rst), .start(start_s), .in_valid(in_valid_s), .in_ready(in_ready_s),
        .in_data(in_data_s), .lb_valid(lb_valid_s), .lb_zero(lb_zero_s), .lb_data(lb_data_s),
        .win_valid(win_valid_s), .win_ready(win_ready_s), .busy(busy_s), .done(done_s)
    );

    typedef struct {
        int iv_mode;
        int stall;
        int shifts;
        int ins;
        int winv;
        int wins;
        int dones;
    } vec_t;

    vec_t vecs[4];
    int   exp_win[9];
    int   checks = 0;
    int   errors = 0;
    int   n_shift, n_in, n_winv, n_win, n_done, zero_err, data_err, stall_err, win_end;
    int   hist[64];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic run_frame(input int iv_mode, input int stall, input int abort_at);
        int  pix, stall_left, tail, r, c;
        bit  stalling, stalled, resume_chk, done_seen, hs, exp_pad;
        pix = 1; stall_left = 0; tail = 0;
        stalling = 0; stalled = 0; resume_chk = 0; done_seen = 0;
        n_shift = 0; n_in = 0; n_winv = 0; n_win = 0; n_done = 0;
        zero_err = 0; data_err = 0; stall_err = 0; win_end = -1;
        @(posedge clk); #1;
        start = 1'b1; in_valid = 1'b1; win_ready = 1'b1; in_data = 16'(pix);
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            hs = 0;
            if (win_valid) begin
                n_winv++;
                if (win_end < 0) win_end = n_shift - 1;
            end
            if (win_valid && win_ready) n_win++;
            if (lb_valid && n_shift < 64) begin
                r = n_shift / PW;
                c = n_shift % PW;
                exp_pad = (r < 1) || (r > 5) || (c < 1) || (c > 5);
                if (lb_zero != exp_pad) zero_err++;
                if (!lb_zero && int'(lb_data) != pix) data_err++;
                hist[n_shift] = lb_zero ? 0 : int'(lb_data);
                n_shift++;
            end
            if (in_valid && in_ready) begin
                n_in++;
                hs = 1;
            end
            if (stalling) begin
                if (lb_valid) stall_err++;
                if (!win_valid) stall_err++;
            end
            if (resume_chk) begin
                resume_chk = 0;
                if (iv_mode == 0 && !lb_valid) stall_err++;
            end
            if (done) begin
                n_done++;
                done_seen = 1;
            end
            if (abort_at > 0 && n_shift == abort_at) return;
            if (done_seen) begin
                tail++;
                if (tail > 3) break;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (hs) pix++;
            in_data  = 16'(pix);
            in_valid = (iv_mode == 0) ? 1'b1 : ~in_valid;
            if (stalling) begin
                stall_left--;
                if (stall_left == 0) begin
                    stalling   = 0;
                    win_ready  = 1'b1;
                    resume_chk = 1;
                end
            end else if (stall > 0 && !stalled && win_valid) begin
                stalling   = 1;
                stalled    = 1;
                stall_left = stall;
                win_ready  = 1'b0;
            end
        end
    endtask

    task automatic check_frame(input string tag, input vec_t v);
        check({tag, "_shifts"}, n_shift, v.shifts);
        check({tag, "_inputs"}, n_in, v.ins);
        check({tag, "_winv_cycles"}, n_winv, v.winv);
        check({tag, "_windows"}, n_win, v.wins);
        check({tag, "_done"}, n_done, v.dones);
        check({tag, "_zero_pattern_errs"}, zero_err, 0);
        check({tag, "_data_errs"}, data_err, 0);
        check({tag, "_stall_errs"}, stall_err, 0);
        check({tag, "_busy_after"}, int'(busy), 0);
    endtask

    task automatic check_window(input string tag);
        check({tag, "_win_end"}, win_end, 16);
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 3; j++)
                if (win_end >= 16)
                    check($sformatf("%s_win_%0d_%0d", tag, k, j),
                          hist[win_end - (2 - k) * PW - (2 - j)], exp_win[k * 3 + j]);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_in_ready"}, int'(in_ready), 0);
        check({tag, "_lb_valid"}, int'(lb_valid), 0);
        check({tag, "_win_valid"}, int'(win_valid), 0);
        check({tag, "_done"}, int'(done), 0);
    endtask

    initial begin
        int s_shift, s_zero, s_win, s_done;
        vecs[0] = '{0, 0, 49, 25, 25, 25, 1};
        vecs[1] = '{1, 0, 49, 25, 25, 25, 1};
        vecs[2] = '{0, 10, 49, 25, 35, 25, 1};
        vecs[3] = '{1, 10, 49, 25, 35, 25, 1};
        exp_win = '{0, 0, 0, 0, 1, 2, 0, 6, 7};

        start = 1'b0; in_valid = 1'b1; win_ready = 1'b1; in_data = '0;
        start_s = 1'b0; in_valid_s = 1'b0; win_ready_s = 1'b1; in_data_s = 16'h00AA;
        #12;
        check_idle_outputs("reset");
        @(negedge clk) rst = 1'b1;

        for (int i = 0; i < 4; i++) begin
            run_frame(vecs[i].iv_mode, vecs[i].stall, 0);
            check_frame($sformatf("vec%0d", i), vecs[i]);
            if (vecs[i].iv_mode == 0) check_window($sformatf("vec%0d", i));
        end

        // Reset part-way through a frame must take effect without a clock edge.
        run_frame(0, 0, 20);
        #2 rst = 1'b0;
        #1 check_idle_outputs("midreset");
        @(negedge clk) rst = 1'b1;
        run_frame(0, 0, 0);
        check_frame("after_reset", vecs[0]);
        check_window("after_reset");

        s_shift = 0; s_zero = 0; s_win = 0; s_done = 0;
        @(posedge clk); #1;
        start_s = 1'b1; in_valid_s = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (lb_valid_s) s_shift++;
            if (lb_valid_s && lb_zero_s) s_zero++;
            if (win_valid_s && win_ready_s) s_win++;
            if (done_s) s_done++;
            @(posedge clk); #1;
            start_s = (cyc == 3);
        end
        check("nopad_shifts", s_shift, 9);
        check("nopad_zero", s_zero, 0);
        check("nopad_windows", s_win, 1);
        check("nopad_done", s_done, 1);
        check("nopad_busy_after", int'(busy_s), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
